// File: rtl/zmips_pkg.sv
// Shared encodings and helpers for the zMIPS multiply/divide unit.
package zmips_pkg;

  localparam int ZMIPS_MDU_ITER = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_t;

  // Two's-complement magnitude when take is set, raw value otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic take);
    logic [31:0] r;
    if (take && v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/zmips_mdu_step.sv
// One iteration of the MDU datapath: radix-2 shift-add, and (with ZMIPS_MDU_DIV_EN)
// the restoring shift-subtract step.
module zmips_mdu_step (
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
`ifdef ZMIPS_MDU_DIV_EN
  input  logic        is_div,
`endif
  output logic [63:0] acc_next
);

  logic [32:0] sum;
`ifdef ZMIPS_MDU_DIV_EN
  logic [32:0] shl;
  logic [32:0] diff;
`endif

  // Multiply adds the multiplicand into the upper half, then shifts the carry in.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    acc_next = {sum, acc[31:1]};
`ifdef ZMIPS_MDU_DIV_EN
    shl  = acc[63:31];
    diff = shl - {1'b0, opnd};
    if (is_div) begin
      // diff[32] is the borrow: set means the partial remainder is restored.
      if (!diff[32]) begin
        acc_next = {diff[31:0], acc[30:0], 1'b1};
      end else begin
        acc_next = {shl[31:0], acc[30:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[31:1]};
    end
`endif
  end

endmodule

// File: rtl/zmips_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO for the zMIPS execute stage.
// Divide datapath is present only when ZMIPS_MDU_DIV_EN is defined.
module zmips_mdu
  import zmips_pkg::*;
#(
  parameter int ITER = ZMIPS_MDU_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  mdu_state_t    state_r;
  logic [CW-1:0] cnt_r;
  logic [63:0]   acc_r;
  logic [63:0]   acc_next_s;
  logic [63:0]   prod_fix_s;
  logic [31:0]   opnd_r;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic [31:0]   mag_a_s;
  logic [31:0]   mag_b_s;
  logic          neg_r;
  logic          is_div_r;
  logic          busy_r;
  logic          done_r;
  logic          is_signed_s;
`ifdef ZMIPS_MDU_DIV_EN
  logic          neg_rem_r;
  logic          bzero_r;
  logic [31:0]   a_orig_r;
  logic [31:0]   quo_fix_s;
  logic [31:0]   rem_fix_s;
`endif

  assign is_signed_s = ~op[0];
  assign mag_a_s     = mag32(a, is_signed_s);
  assign mag_b_s     = mag32(b, is_signed_s);

  zmips_mdu_step u_step (
    .acc      (acc_r),
    .opnd     (opnd_r),
`ifdef ZMIPS_MDU_DIV_EN
    .is_div   (is_div_r),
`endif
    .acc_next (acc_next_s)
  );

  // Sign correction of the finished magnitude result.
  always_comb begin
    if (neg_r) begin
      prod_fix_s = ~acc_r + 64'd1;
    end else begin
      prod_fix_s = acc_r;
    end
`ifdef ZMIPS_MDU_DIV_EN
    if (neg_r) begin
      quo_fix_s = ~acc_r[31:0] + 32'd1;
    end else begin
      quo_fix_s = acc_r[31:0];
    end
    if (neg_rem_r) begin
      rem_fix_s = ~acc_r[63:32] + 32'd1;
    end else begin
      rem_fix_s = acc_r[63:32];
    end
`endif
  end

  // Control FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= MDU_IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= 64'd0;
      opnd_r   <= 32'd0;
      neg_r    <= 1'b0;
      is_div_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
`ifdef ZMIPS_MDU_DIV_EN
      neg_rem_r <= 1'b0;
      bzero_r   <= 1'b0;
      a_orig_r  <= 32'd0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        MDU_IDLE: begin
          if (hilo_we) begin
            if (hilo_sel) begin
              hi_r <= wdata;
            end else begin
              lo_r <= wdata;
            end
          end
          if (start) begin
            // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
            acc_r    <= {32'd0, op[1] ? mag_a_s : mag_b_s};
            opnd_r   <= op[1] ? mag_b_s : mag_a_s;
            neg_r    <= (a[31] ^ b[31]) & is_signed_s;
            is_div_r <= op[1];
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
`ifdef ZMIPS_MDU_DIV_EN
            neg_rem_r <= a[31] & is_signed_s;
            bzero_r   <= (b == 32'd0);
            a_orig_r  <= a;
            state_r   <= MDU_CALC;
`else
            state_r   <= op[1] ? MDU_FIX : MDU_CALC;
`endif
          end
        end
        MDU_CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(ITER - 1)) begin
            state_r <= MDU_FIX;
          end
        end
        MDU_FIX: begin
          state_r <= MDU_IDLE;
          cnt_r   <= {CW{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          if (!is_div_r) begin
            hi_r <= prod_fix_s[63:32];
            lo_r <= prod_fix_s[31:0];
          end else begin
`ifdef ZMIPS_MDU_DIV_EN
            if (bzero_r) begin
              hi_r <= a_orig_r;
              lo_r <= 32'hFFFF_FFFF;
            end else begin
              hi_r <= rem_fix_s;
              lo_r <= quo_fix_s;
            end
`else
            hi_r <= hi_r;
            lo_r <= lo_r;
`endif
          end
        end
        default: begin
          state_r <= MDU_IDLE;
          cnt_r   <= {CW{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign hi      = hi_r;
  assign lo      = lo_r;
  assign rd_data = hilo_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_zmips_mdu.sv
// Scoreboard bench for zmips_mdu: expected HI/LO are queued at launch and popped on done.
module tb_zmips_mdu;
  import zmips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mhi;
  logic [31:0] mlo;

`ifdef ZMIPS_MDU_DIV_EN
  localparam int DIV_BUSY = 33;
`else
  localparam int DIV_BUSY = 1;
`endif

  always #5 clk = ~clk;

  zmips_mdu dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] ph,
                                        input logic [31:0] pl);
    longint sx, sy, p, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = {ph, pl};
    if (o == 2'b00) begin
      p = sx * sy;
      res = p;
    end else if (o == 2'b01) begin
      res = {32'd0, x} * {32'd0, y};
    end else begin
`ifdef ZMIPS_MDU_DIV_EN
      if (y == 32'd0) begin
        res = {x, 32'hFFFF_FFFF};
      end else if (o == 2'b10) begin
        q = sx / sy;
        r = sx % sy;
        res = {r[31:0], q[31:0]};
      end else begin
        res = {x % y, x / y};
      end
`endif
    end
    return res;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    op = o; a = x; b = y; start = 1'b1;
    e = model(o, x, y, mhi, mlo);
    exp_q.push_back(e);
    mhi = e[63:32];
    mlo = e[31:0];
  endtask

  task automatic wait_done(output int nbusy, output logic done_seen, output logic early);
    nbusy = 0;
    early = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      hilo_we = 1'b0;
      if (!busy) break;
      nbusy++;
      if (done) early = 1'b1;
    end
    done_seen = done;
  endtask

  task automatic write_hilo(input logic sel, input logic [31:0] d);
    hilo_we = 1'b1; hilo_sel = sel; wdata = d;
    @(negedge clk);
    hilo_we = 1'b0;
    if (sel) mhi = d; else mlo = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    hilo_we = 1'b0; hilo_sel = 1'b0; wdata = 32'd0;
    mhi = 32'd0; mlo = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
  endtask

  task automatic test_hilo_write;
    write_hilo(1'b0, 32'h1357_9BDF);
    write_hilo(1'b1, 32'h2468_ACE0);
    total++; if (lo !== 32'h1357_9BDF) begin bad++; $display("FAIL mtlo got=%h want=13579bdf", lo); end
    total++; if (hi !== 32'h2468_ACE0) begin bad++; $display("FAIL mthi got=%h want=2468ace0", hi); end
    hilo_sel = 1'b0; #1;
    total++; if (rd_data !== 32'h1357_9BDF) begin bad++; $display("FAIL rd_lo got=%h want=13579bdf", rd_data); end
    hilo_sel = 1'b1; #1;
    total++; if (rd_data !== 32'h2468_ACE0) begin bad++; $display("FAIL rd_hi got=%h want=2468ace0", rd_data); end
    @(negedge clk);
  endtask

  task automatic test_mul;
    logic [1:0]  ops [5] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [31:0] xs  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0000, 32'h0000_0007};
    logic [31:0] ys  [5] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    logic [63:0] e;
    int nb;
    logic ds, early;
    hilo_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      launch(ops[i], xs[i], ys[i]);
      wait_done(nb, ds, early);
      e = exp_q.pop_front();
      total++; if (nb !== 33) begin bad++; $display("FAIL mul_busy[%0d] got=%0d want=33", i, nb); end
      total++; if (ds !== 1'b1 || early) begin bad++; $display("FAIL mul_done[%0d] got=%b early=%b want=1", i, ds, early); end
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL mul_hilo[%0d] got=%h want=%h", i, {hi, lo}, e); end
      total++; if (rd_data !== e[31:0]) begin bad++; $display("FAIL mul_rd[%0d] got=%h want=%h", i, rd_data, e[31:0]); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse[%0d] got=%b want=0", i, done); end
    end
  endtask

  task automatic test_div;
    logic [1:0]  ops [6] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [31:0] xs  [6] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    logic [31:0] ys  [6] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFD, 32'd7, 32'd0};
    logic [63:0] e;
    int nb;
    logic ds, early;
    write_hilo(1'b1, 32'hAAAA_0001);
    write_hilo(1'b0, 32'h5555_0002);
    for (int i = 0; i < 6; i++) begin
      launch(ops[i], xs[i], ys[i]);
      wait_done(nb, ds, early);
      e = exp_q.pop_front();
      total++; if (nb !== DIV_BUSY) begin bad++; $display("FAIL div_busy[%0d] got=%0d want=%0d", i, nb, DIV_BUSY); end
      total++; if (ds !== 1'b1 || early) begin bad++; $display("FAIL div_done[%0d] got=%b early=%b want=1", i, ds, early); end
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL div_hilo[%0d] got=%h want=%h", i, {hi, lo}, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore;
    logic [63:0] e;
    logic [31:0] hi_before;
    int nb;
    hi_before = hi;
    launch(2'b01, 32'd3, 32'd4);
    nb = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      start = 1'b0;
      hilo_we = 1'b0;
      if (!busy) break;
      nb++;
      if (j == 4) begin hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'h0000_1234; end
      if (j == 6) begin
        total++; if (hi !== hi_before) begin bad++; $display("FAIL busy_write got=%h want=%h", hi, hi_before); end
      end
      if (j == 9) begin start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd7; end
    end
    e = exp_q.pop_front();
    total++; if (nb !== 33) begin bad++; $display("FAIL ign_busy got=%0d want=33", nb); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done got=%b want=1", done); end
    total++; if ({hi, lo} !== e) begin bad++; $display("FAIL ign_hilo got=%h want=%h", {hi, lo}, e); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ign_second got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_we_with_start;
    logic [63:0] e;
    int nb;
    logic ds, early;
    hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'h0000_BEEF;
    launch(2'b01, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    total++; if (hi !== 32'h0000_BEEF) begin bad++; $display("FAIL we_start_hi got=%h want=0000beef", hi); end
    wait_done(nb, ds, early);
    e = exp_q.pop_front();
    total++; if (nb !== 32 || ds !== 1'b1) begin bad++; $display("FAIL we_start_timing got busy=%0d done=%b want 32 1", nb, ds); end
    total++; if ({hi, lo} !== e) begin bad++; $display("FAIL we_start_hilo got=%h want=%h", {hi, lo}, e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    int nb;
    logic ds, early;
    launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(nb, ds, early);
    e = exp_q.pop_front();
    total++; if ({hi, lo} !== e || ds !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h done=%b want=%h", {hi, lo}, ds, e); end
    launch(2'b00, 32'hFFFF_0000, 32'h0001_2345);
    wait_done(nb, ds, early);
    e = exp_q.pop_front();
    total++; if (nb !== 33 || ds !== 1'b1) begin bad++; $display("FAIL b2b_timing got busy=%0d done=%b want 33 1", nb, ds); end
    total++; if ({hi, lo} !== e) begin bad++; $display("FAIL b2b_second got=%h want=%h", {hi, lo}, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen;
    write_hilo(1'b1, 32'hCAFE_0001);
    write_hilo(1'b0, 32'hCAFE_0002);
    launch(2'b01, 32'd5, 32'd6);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 14) rst_n = 1'b0;
    end
    void'(exp_q.pop_front());
    mhi = 32'd0; mlo = 32'd0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl got busy=%b done=%b want 0 0", busy, done); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL rst_mid_hilo got=%h want=0", {hi, lo}); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_resume got activity=%b want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_hilo_write();
    test_mul();
    test_div();
    test_ignore();
    test_we_with_start();
    test_back_to_back();
    test_reset_mid();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
